proximo_pc: RTL

// - Next-address stage directly upstream of the program counter: computes the value on pc.entrada.
// - Chooses sequential, relative branch, absolute jump, call or return from current pc.endereco and

---
 rtl/proximo_pc_pkg.sv | 19 +
 rtl/proximo_pc_pilha_retorno.sv | 58 +++++
 rtl/proximo_pc.sv | 102 ++++++++++
 3 files changed

// File: rtl/proximo_pc_pkg.sv
// Shared constants for the next-address stage: default sizes, reset address
// and the source-select encoding used by the output mux.
package proximo_pc_pkg;

    localparam int         LARGURA_PAD   = 8;
    localparam int         PROF_PAD      = 4;
    localparam logic [7:0] END_RESET_PAD = 8'h00;

    localparam int SEL_W = 3;
    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_SEQ     = 3'd0;
    localparam sel_t SEL_PARADA  = 3'd1;
    localparam sel_t SEL_DESVIO  = 3'd2;
    localparam sel_t SEL_SALTO   = 3'd3;
    localparam sel_t SEL_CHAMADA = 3'd4;
    localparam sel_t SEL_RETORNO = 3'd5;

endpackage

// File: rtl/proximo_pc_pilha_retorno.sv
// Return-address LIFO: PROF entries of LARGURA bits, top visible combinationally.
// Push on full and pop on empty are silently ignored; the caller flags them.
module pilha_retorno
    import proximo_pc_pkg::*;
#(
    parameter int LARGURA = LARGURA_PAD,
    parameter int PROF    = PROF_PAD
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [LARGURA-1:0] dado,
    output logic [LARGURA-1:0] topo,
    output logic               vazia,
    output logic               cheia
);

    localparam int IW = $clog2(PROF);
    localparam int CW = IW + 1;

    logic [LARGURA-1:0] mem_q [PROF];
    logic [CW-1:0]      cont_q;
    logic [CW-1:0]      cont_d;
    logic [IW-1:0]      ind_topo;

    // Index of the newest entry; meaningless when empty, and then topo is unused.
    assign ind_topo = IW'(cont_q - CW'(1));
    assign topo     = mem_q[ind_topo];
    assign vazia    = (cont_q == '0);
    assign cheia    = (cont_q == CW'(PROF));

    always_comb begin
        cont_d = cont_q;
        if (push && !cheia) begin
            cont_d = cont_q + CW'(1);
        end else if (pop && !vazia) begin
            cont_d = cont_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !cheia) begin
            mem_q[cont_q[IW-1:0]] <= dado;
        end
    end

    a_push_pop_exclusivos: assert property (@(posedge clock) disable iff (reset) !(push && pop));

endmodule

// File: rtl/proximo_pc.sv
// Next-address stage feeding pc.entrada: priority select between stall, return,
// call, jump, relative branch and sequential, plus a return stack and sticky error.
module proximo_pc
    import proximo_pc_pkg::*;
#(
    parameter int                 LARGURA   = LARGURA_PAD,
    parameter int                 PROF      = PROF_PAD,
    parameter logic [LARGURA-1:0] END_RESET = LARGURA'(END_RESET_PAD)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] endereco,
    input  logic               parada,
    input  logic               desvio,
    input  logic               salto,
    input  logic               chamada,
    input  logic               retorno,
    input  logic [LARGURA-1:0] imediato,
    output logic [LARGURA-1:0] proximo,
    output logic               pilha_vazia,
    output logic               pilha_cheia,
    output logic               erro_pilha
);

    sel_t               sel;
    logic [LARGURA-1:0] seq;
    logic [LARGURA-1:0] alvo_desvio;
    logic [LARGURA-1:0] topo;
    logic               vazia;
    logic               cheia;
    logic               push;
    logic               pop;
    logic               erro_q;
    logic               erro_d;

    always_comb begin
        sel = SEL_SEQ;
        if (parada) begin
            sel = SEL_PARADA;
        end else if (retorno) begin
            sel = SEL_RETORNO;
        end else if (chamada) begin
            sel = SEL_CHAMADA;
        end else if (salto) begin
            sel = SEL_SALTO;
        end else if (desvio) begin
            sel = SEL_DESVIO;
        end
    end

    // Same-width adds wrap modulo 2^LARGURA; imediato acts as a signed offset.
    assign seq         = endereco + LARGURA'(1);
    assign alvo_desvio = endereco + imediato;

    assign push = !reset && (sel == SEL_CHAMADA);
    assign pop  = !reset && (sel == SEL_RETORNO);

    pilha_retorno #(
        .LARGURA (LARGURA),
        .PROF    (PROF)
    ) u_pilha (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .dado  (seq),
        .topo  (topo),
        .vazia (vazia),
        .cheia (cheia)
    );

    always_comb begin
        proximo = seq;
        if (reset) begin
            proximo = END_RESET;
        end else begin
            case (sel)
                SEL_PARADA:  proximo = endereco;
                SEL_RETORNO: proximo = vazia ? seq : topo;
                SEL_CHAMADA: proximo = imediato;
                SEL_SALTO:   proximo = imediato;
                SEL_DESVIO:  proximo = alvo_desvio;
                default:     proximo = seq;
            endcase
        end
    end

    assign erro_d = erro_q | (push && cheia) | (pop && vazia);

    always_ff @(posedge clock) begin
        if (reset) begin
            erro_q <= 1'b0;
        end else begin
            erro_q <= erro_d;
        end
    end

    assign pilha_vazia = reset | vazia;
    assign pilha_cheia = !reset & cheia;
    assign erro_pilha  = erro_q;

endmodule
